prog_mem_loadable: RTL

Parametrised, synchronous program memory for the 16-bit MCU, replacing the hard-coded combinational instruction ROM. Serves instruction fetches with one-cycle registered latency. Contains a loader FSM that streams a program image into any address window at run time (boot, ISR region at 0xF00), so the memory does not need resynthesising per test program. Sits between the fetch stage (PC) and the boot/debug loader.

---
 rtl/prog_mem_loadable.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable
//
// Synchronous program memory for the 16-bit MCU. Instruction fetches are
// served with one cycle of registered latency. A small loader FSM can
// stream a program image into any window of the memory at run time, so
// test programs and ISR images do not require a resynthesis.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_i           synchronous, active-high reset (memory contents kept)
//   fetch_req_i     fetch request, sampled at posedge
//   fetch_addr_i    fetch address (PC)
//   instr_out_o     fetched instruction, registered
//   instr_valid_o   one-cycle pulse, instr_out_o holds last cycle's request
//   busy_o          high while loading (LOAD/DONE), fetch is stalled
//   load_start_i    begin a load (honoured in RUN only)
//   load_base_i     first write address, captured on load_start_i
//   load_len_i      word count, captured on load_start_i
//   load_valid_i    load_data_i is valid
//   load_data_i     image word
//   load_ready_o    loader accepts a word this cycle
//   load_done_o     one-cycle pulse after the last word is written
//   load_err_o      one-cycle pulse when load_start_i is rejected
//   parity_err_o    read parity mismatch (only with PM_PARITY_EN)
//
// Optional feature macro: PM_PARITY_EN
//   When defined, every stored word carries an even-parity bit computed on
//   write and checked on each in-range read. A mismatch returns HALT_WORD
//   and raises parity_err_o alongside instr_valid_o. When undefined, the
//   memory is DATA_W wide and parity_err_o is tied low.

module prog_mem_loadable #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 12,
  parameter int                 DEPTH     = 4096,
  parameter logic [DATA_W-1:0]  HALT_WORD = 16'h5000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] instr_out_o,
  output logic              instr_valid_o,
  output logic              busy_o,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic              parity_err_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef PM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // Bounds are compared one/two bits wider than the address so that a
  // window ending exactly at DEPTH (or DEPTH == 2**ADDR_W) never wraps.
  localparam logic [ADDR_W+1:0] DEPTH_LOAD  = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_FETCH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              load_err_q, load_err_d;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              parity_err_q;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [ADDR_W+1:0] load_end;
  logic              start_bad;
  logic              wr_en;
  logic              fetch_en;
  logic              fetch_in_range;
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  ptr_idx;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  assign load_end       = {2'b00, load_base_i} + {1'b0, load_len_i};
  assign start_bad      = (load_len_i == '0) || (load_end > DEPTH_LOAD);
  assign fetch_en       = (state_q == ST_RUN) && fetch_req_i;
  assign fetch_in_range = ({1'b0, fetch_addr_i} < DEPTH_FETCH);
  assign fetch_idx      = fetch_addr_i[IDX_W-1:0];
  assign ptr_idx        = ptr_q[IDX_W-1:0];

  // Reset has priority over an in-flight load word: an aborted load must
  // leave the word presented in the reset cycle unwritten.
  assign wr_en = (state_q == ST_LOAD) && load_valid_i && !rst_i;

`ifdef PM_PARITY_EN
  assign wr_word = {^load_data_i, load_data_i};
`else
  assign wr_word = load_data_i;
`endif

  assign rd_word = mem[fetch_idx];

  // Loader FSM: next state, window pointer and remaining word count.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    load_err_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_start_i) begin
          if (start_bad) begin
            load_err_d = 1'b1;
          end else begin
            ptr_d   = load_base_i;
            cnt_d   = load_len_i;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_valid_i) begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q - (ADDR_W+1)'(1);
          if (cnt_q == (ADDR_W+1)'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      ptr_q      <= '0;
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end

  // Storage array is deliberately not reset so it maps onto block RAM and
  // keeps its image across a CPU reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[ptr_idx] <= wr_word;
    end
  end

  // Fetch port. Unimplemented addresses return HALT_WORD and never flag
  // parity; instr_out_o holds its value between requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q       <= HALT_WORD;
      instr_valid_q <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      instr_valid_q <= fetch_en;
      parity_err_q  <= 1'b0;
      if (fetch_en) begin
        if (!fetch_in_range) begin
          instr_q <= HALT_WORD;
        end else begin
`ifdef PM_PARITY_EN
          if (^rd_word) begin
            instr_q      <= HALT_WORD;
            parity_err_q <= 1'b1;
          end else begin
            instr_q <= rd_word[DATA_W-1:0];
          end
`else
          instr_q <= rd_word;
`endif
        end
      end
    end
  end

  assign instr_out_o   = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign busy_o        = (state_q != ST_RUN);
  assign load_ready_o  = (state_q == ST_LOAD);
  assign load_done_o   = (state_q == ST_DONE);
  assign load_err_o    = load_err_q;
  assign parity_err_o  = parity_err_q;

endmodule
